// File: rtl/usbls_setup_gen.sv
// USB low-speed SETUP data-stage generator: builds the 8-byte request for the selected
// standard/HID/custom transfer and streams it byte-wise (valid/ready), optionally with CRC16.
module usbls_setup_gen #(
  parameter int CFG_LEN     = 9,
  parameter int HID_RPT_LEN = 129,
  parameter int STR_LEN     = 4,
  parameter int CFG_VALUE   = 1,
  parameter int RPT_LEN     = 1,
  parameter bit APPEND_CRC  = 1'b1,
  parameter bit BIT_REV     = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  req_sel,
  input  logic [6:0]  dev_addr,
  input  logic [7:0]  str_idx,
  input  logic [63:0] custom_pkt,
  input  logic        abort,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic [63:0] pkt_snapshot,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [15:0] CFG_W = 16'(CFG_LEN);
  localparam logic [15:0] HID_W = 16'(HID_RPT_LEN);
  localparam logic [15:0] STR_W = 16'(STR_LEN);
  localparam logic [15:0] RPT_W = 16'(RPT_LEN);
  localparam logic [7:0]  CFG_V = 8'(CFG_VALUE);

  typedef enum logic [2:0] {IDLE, LOAD, DATA, CRC_LO, CRC_HI, FIN} state_t;

  state_t      state;
  logic [2:0]  idx;
  logic [2:0]  nxt_idx;
  logic [15:0] crc;
  logic [15:0] crc_next;
  logic [63:0] req_pkt;
  logic [7:0]  cur_byte;
  logic [7:0]  nxt_byte;

  // Reflected form of poly 0x8005: data enters LSB first, so ~crc[7:0] is already wire order.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  function automatic logic [7:0] out_map(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (BIT_REV)
      for (int i = 0; i < 8; i++)
        r[i] = b[7-i];
    return r;
  endfunction

  // Request table; 16-bit wLength fields go out little-endian.
  always_comb begin
    req_pkt = 64'h0;
    case (req_sel)
      4'd0:  req_pkt = {8'h00, 8'h05, 1'b0, dev_addr, 8'h00, 32'h0};
      4'd1:  req_pkt = {8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h12, 8'h00};
      4'd2:  req_pkt = {8'h80, 8'h06, 8'h00, 8'h02, 8'h00, 8'h00, CFG_W[7:0], CFG_W[15:8]};
      4'd3:  req_pkt = {8'h80, 8'h06, 8'h00, 8'h04, 8'h00, 8'h00, CFG_W[7:0], CFG_W[15:8]};
      4'd4:  req_pkt = {8'h80, 8'h06, 8'h00, 8'h05, 8'h00, 8'h00, 8'h07, 8'h00};
      4'd5:  req_pkt = {8'h80, 8'h06, str_idx, 8'h03, 8'h00, 8'h00, STR_W[7:0], STR_W[15:8]};
      4'd6:  req_pkt = {8'h00, 8'h09, CFG_V, 8'h00, 32'h0};
      4'd7:  req_pkt = {8'h21, 8'h0A, 48'h0};
      4'd8:  req_pkt = {8'h81, 8'h06, 8'h00, 8'h22, 8'h00, 8'h00, HID_W[7:0], HID_W[15:8]};
      4'd9:  req_pkt = {8'h21, 8'h09, 8'h00, 8'h02, 8'h00, 8'h00, RPT_W[7:0], RPT_W[15:8]};
      4'd10: req_pkt = custom_pkt;
      default: req_pkt = 64'h0;
    endcase
  end

  assign nxt_idx  = idx + 3'd1;
  assign cur_byte = pkt_snapshot[{~idx, 3'b000} +: 8];
  assign nxt_byte = pkt_snapshot[{~nxt_idx, 3'b000} +: 8];
  assign crc_next = crc_step(crc, cur_byte);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= 3'd0;
      crc          <= 16'hFFFF;
      tx_byte      <= 8'h00;
      tx_valid     <= 1'b0;
      tx_last      <= 1'b0;
      pkt_snapshot <= 64'h0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (abort && state != IDLE) begin
        state    <= IDLE;
        tx_valid <= 1'b0;
        tx_last  <= 1'b0;
        tx_byte  <= 8'h00;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              if (req_sel <= 4'd10) begin
                pkt_snapshot <= req_pkt;
                busy         <= 1'b1;
                state        <= LOAD;
              end else begin
                err <= 1'b1;
              end
            end
          end
          LOAD: begin
            idx      <= 3'd0;
            crc      <= 16'hFFFF;
            tx_byte  <= out_map(pkt_snapshot[63:56]);
            tx_valid <= 1'b1;
            tx_last  <= 1'b0;
            state    <= DATA;
          end
          DATA: begin
            if (tx_valid && tx_ready) begin
              crc <= crc_next;
              if (idx == 3'd7) begin
                if (APPEND_CRC) begin
                  tx_byte <= out_map(~crc_next[7:0]);
                  tx_last <= 1'b0;
                  state   <= CRC_LO;
                end else begin
                  tx_byte  <= 8'h00;
                  tx_valid <= 1'b0;
                  tx_last  <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= FIN;
                end
              end else begin
                idx     <= nxt_idx;
                tx_byte <= out_map(nxt_byte);
                tx_last <= (nxt_idx == 3'd7) && !APPEND_CRC;
              end
            end
          end
          CRC_LO: begin
            if (tx_valid && tx_ready) begin
              tx_byte <= out_map(~crc[15:8]);
              tx_last <= 1'b1;
              state   <= CRC_HI;
            end
          end
          CRC_HI: begin
            if (tx_valid && tx_ready) begin
              tx_byte  <= 8'h00;
              tx_valid <= 1'b0;
              tx_last  <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= FIN;
            end
          end
          FIN: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usbls_setup_gen.sv
// Directed + randomized bench for usbls_setup_gen: a request-table/CRC reference model
// predicts every streamed byte, snapshot and handshake event.
module tb_usbls_setup_gen;

  localparam int CFG_LEN = 9, HID_RPT_LEN = 129, STR_LEN = 4, CFG_VALUE = 1, RPT_LEN = 1;

  logic        clk, rst_n, start, abort, tx_ready;
  logic [3:0]  req_sel;
  logic [6:0]  dev_addr;
  logic [7:0]  str_idx;
  logic [63:0] custom_pkt;

  logic [7:0]  tx_byte, r_tx_byte;
  logic        tx_valid, tx_last, busy, done, err;
  logic        r_tx_valid, r_tx_last, r_busy, r_done, r_err;
  logic [63:0] pkt_snapshot, r_pkt_snapshot;

  int checks = 0;
  int failures = 0;
  bit sel_rev = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [63:0] exp_snap;

  usbls_setup_gen #(.CFG_LEN(CFG_LEN), .HID_RPT_LEN(HID_RPT_LEN), .STR_LEN(STR_LEN),
                    .CFG_VALUE(CFG_VALUE), .RPT_LEN(RPT_LEN), .APPEND_CRC(1'b1), .BIT_REV(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .req_sel(req_sel), .dev_addr(dev_addr),
    .str_idx(str_idx), .custom_pkt(custom_pkt), .abort(abort), .tx_byte(tx_byte),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last), .pkt_snapshot(pkt_snapshot),
    .busy(busy), .done(done), .err(err));

  usbls_setup_gen #(.CFG_LEN(CFG_LEN), .HID_RPT_LEN(HID_RPT_LEN), .STR_LEN(STR_LEN),
                    .CFG_VALUE(CFG_VALUE), .RPT_LEN(RPT_LEN), .APPEND_CRC(1'b0), .BIT_REV(1'b1)) dut_rev (
    .clk(clk), .rst_n(rst_n), .start(start), .req_sel(req_sel), .dev_addr(dev_addr),
    .str_idx(str_idx), .custom_pkt(custom_pkt), .abort(abort), .tx_byte(r_tx_byte),
    .tx_valid(r_tx_valid), .tx_ready(tx_ready), .tx_last(r_tx_last), .pkt_snapshot(r_pkt_snapshot),
    .busy(r_busy), .done(r_done), .err(r_err));

  logic [7:0]  o_byte;
  logic        o_valid, o_last, o_busy, o_done, o_err;
  logic [63:0] o_snap;
  assign o_byte  = sel_rev ? r_tx_byte : tx_byte;
  assign o_valid = sel_rev ? r_tx_valid : tx_valid;
  assign o_last  = sel_rev ? r_tx_last : tx_last;
  assign o_busy  = sel_rev ? r_busy : busy;
  assign o_done  = sel_rev ? r_done : done;
  assign o_err   = sel_rev ? r_err : err;
  assign o_snap  = sel_rev ? r_pkt_snapshot : pkt_snapshot;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Textbook shift-left CRC16 (poly 0x8005), message bits fed LSB first.
  function automatic logic [15:0] crc16_n(input logic [7:0] d[$]);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    foreach (d[i])
      for (int k = 0; k < 8; k++) begin
        fb = c[15] ^ d[i][k];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    return c;
  endfunction

  // Builds the expected packet, snapshot and output stream from the request table.
  task automatic setup_req(input int sel, input bit with_crc, input bit rev);
    logic [7:0]  b[8];
    logic [7:0]  nat[$];
    logic [15:0] len, c;
    for (int i = 0; i < 8; i++) b[i] = 8'h00;
    len = 16'h0;
    case (sel)
      0:  begin b[1] = 8'h05; b[2] = {1'b0, dev_addr}; end
      1:  begin b[0] = 8'h80; b[1] = 8'h06; b[3] = 8'h01; len = 16'd18; end
      2:  begin b[0] = 8'h80; b[1] = 8'h06; b[3] = 8'h02; len = 16'(CFG_LEN); end
      3:  begin b[0] = 8'h80; b[1] = 8'h06; b[3] = 8'h04; len = 16'(CFG_LEN); end
      4:  begin b[0] = 8'h80; b[1] = 8'h06; b[3] = 8'h05; len = 16'd7; end
      5:  begin b[0] = 8'h80; b[1] = 8'h06; b[2] = str_idx; b[3] = 8'h03; len = 16'(STR_LEN); end
      6:  begin b[1] = 8'h09; b[2] = 8'(CFG_VALUE); end
      7:  begin b[0] = 8'h21; b[1] = 8'h0A; end
      8:  begin b[0] = 8'h81; b[1] = 8'h06; b[3] = 8'h22; len = 16'(HID_RPT_LEN); end
      9:  begin b[0] = 8'h21; b[1] = 8'h09; b[3] = 8'h02; len = 16'(RPT_LEN); end
      default: ;
    endcase
    if (sel == 10) begin
      for (int i = 0; i < 8; i++) b[i] = custom_pkt[63-8*i -: 8];
    end else begin
      b[6] = len[7:0];
      b[7] = len[15:8];
    end
    exp_snap = {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
    nat.delete();
    for (int i = 0; i < 8; i++) nat.push_back(b[i]);
    c = crc16_n(nat);
    if (with_crc) begin
      nat.push_back(rev8(~c[15:8]));
      nat.push_back(rev8(~c[7:0]));
    end
    exp_q.delete();
    foreach (nat[i]) exp_q.push_back(rev ? rev8(nat[i]) : nat[i]);
  endtask

  task automatic start_req(input logic [3:0] sel);
    start = 1'b1; req_sel = sel;
    @(posedge clk); #1;
    start = 1'b0;
    check("load_busy", o_busy, 1);
    check("load_valid", o_valid, 0);
    check("load_snapshot", o_snap, exp_snap);
    @(posedge clk); #1;
    check("first_valid_t2", o_valid, 1);
  endtask

  task automatic drain();
    tx_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  // Runs one stream, comparing every accepted byte/tx_last against exp_q.
  task automatic run_stream(input bit rand_ready, input int abort_after, input int inject_at);
    int acc = 0, cyc = 0, first_acc = -1, last_acc = -1, done_cyc = -1, dones = 0;
    bit stalled = 0, injected = 0, inj_pending = 0;
    logic [7:0] held_b;
    logic held_l;
    got_q.delete();
    while (cyc < 300) begin
      if (inj_pending) begin
        start = 1'b0; inj_pending = 0;
        check("busy_start_no_err", o_err, 0);
        check("busy_start_snapshot", o_snap, exp_snap);
      end
      if (o_done) begin dones++; done_cyc = cyc; end
      if (stalled) begin
        check("stall_valid", o_valid, 1);
        check("stall_byte", o_byte, held_b);
        check("stall_last", o_last, held_l);
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      if (abort_after > 0 && acc == abort_after) begin
        abort = 1'b1; tx_ready = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_valid", o_valid, 0);
        check("abort_busy", o_busy, 0);
        for (int k = 0; k < 4; k++) begin
          check("abort_no_done", o_done, 0);
          @(posedge clk); #1;
        end
        check("abort_snapshot_kept", o_snap, exp_snap);
        return;
      end
      if (inject_at >= 0 && acc == inject_at && !injected) begin
        start = 1'b1; req_sel = 4'd12; injected = 1; inj_pending = 1;
      end
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_valid && tx_ready) begin
        got_q.push_back(o_byte);
        if (acc < exp_q.size()) check($sformatf("byte%0d", acc), o_byte, exp_q[acc]);
        else check("extra_accept", acc, exp_q.size() - 1);
        check($sformatf("last%0d", acc), o_last, (acc == exp_q.size() - 1));
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        acc++;
        stalled = 0;
      end else begin
        stalled = o_valid;
        held_b  = o_byte;
        held_l  = o_last;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("accept_count", acc, exp_q.size());
    check("done_count", dones, 1);
    check("done_after_last", done_cyc, last_acc + 1);
    if (!rand_ready) check("back_to_back", last_acc - first_acc, exp_q.size() - 1);
    check("idle_busy", o_busy, 0);
    check("idle_valid", o_valid, 0);
  endtask

  initial begin
    int sel;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tx_ready = 1'b0; req_sel = 4'd0;
    dev_addr = 7'h05; str_idx = 8'h00; custom_pkt = 64'h0;
    #12;
    check("rst_tx_byte", tx_byte, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_last", tx_last, 0);
    check("rst_snapshot", pkt_snapshot, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] GET_DEV, ready=1, start injected mid-stream");
    setup_req(1, 1, 0);
    check("get_dev_model_snapshot", exp_snap, 64'h8006000100001200);
    start_req(4'd1);
    run_stream(0, -1, 3);
    check("get_dev_snapshot_const", pkt_snapshot, 64'h8006000100001200);
    drain();

    $display("[TB] SET_ADDR 0x05, CRC residual");
    dev_addr = 7'h05;
    setup_req(0, 1, 0);
    start_req(4'd0);
    run_stream(0, -1, -1);
    check("set_addr_byte2", got_q.size() > 2 ? got_q[2] : 8'hxx, 8'h05);
    check("set_addr_residual", crc16_n(got_q), 16'h800D);
    drain();

    $display("[TB] GET_HID_RPT, random ready");
    setup_req(8, 1, 0);
    start_req(4'd8);
    run_stream(1, -1, -1);
    check("hid_byte6", got_q.size() > 6 ? got_q[6] : 8'hxx, 8'h81);
    check("hid_byte3", got_q.size() > 3 ? got_q[3] : 8'hxx, 8'h22);
    drain();

    $display("[TB] invalid req_sel");
    for (int k = 0; k < 3; k++) begin
      start = 1'b1; req_sel = (k == 0) ? 4'd12 : 4'($urandom_range(11, 15));
      @(posedge clk); #1;
      start = 1'b0;
      check("inv_err_pulse", err, 1);
      check("inv_busy", busy, 0);
      check("inv_valid", tx_valid, 0);
      check("inv_snapshot", pkt_snapshot, exp_snap);
      @(posedge clk); #1;
      check("inv_err_clear", err, 0);
    end

    $display("[TB] abort and start together in IDLE");
    start = 1'b1; abort = 1'b1; req_sel = 4'd7;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_wins_busy", busy, 0);
    check("abort_wins_err", err, 0);
    check("abort_wins_snapshot", pkt_snapshot, exp_snap);
    @(posedge clk); #1;

    $display("[TB] abort after 4th accept, then SET_IDLE");
    setup_req(2, 1, 0);
    start_req(4'd2);
    run_stream(1, 4, -1);
    drain();
    setup_req(7, 1, 0);
    start_req(4'd7);
    run_stream(0, -1, -1);
    drain();

    $display("[TB] randomized requests");
    for (int it = 0; it < 8; it++) begin
      sel = $urandom_range(0, 10);
      dev_addr = 7'($urandom); str_idx = 8'($urandom); custom_pkt = {$urandom, $urandom};
      setup_req(sel, 1, 0);
      start_req(4'(sel));
      run_stream(1, -1, -1);
      drain();
    end

    $display("[TB] BIT_REV instance, CUSTOM packet");
    sel_rev = 1;
    custom_pkt = 64'h0102030405060708;
    setup_req(10, 0, 1);
    check("rev_model_byte0", exp_q[0], 8'h80);
    start_req(4'd10);
    run_stream(0, -1, -1);
    check("rev_byte7", got_q.size() > 7 ? got_q[7] : 8'hxx, 8'h10);
    drain();

    $display("[TB] async reset mid-stream");
    custom_pkt = {$urandom, $urandom};
    setup_req(10, 0, 1);
    start_req(4'd10);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", r_tx_valid | tx_valid, 0);
    check("mid_rst_byte", {r_tx_byte, tx_byte}, 0);
    check("mid_rst_last", r_tx_last | tx_last, 0);
    check("mid_rst_busy", r_busy | busy, 0);
    check("mid_rst_snapshot", r_pkt_snapshot | pkt_snapshot, 0);
    check("mid_rst_done", r_done | done, 0);
    #2 rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_no_done", r_done | done, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usbls_setup_gen.md
Name: usbls_setup_gen

Overview:
- Sequential successor to the combinational setup-descriptor table.
- Builds the 8-byte USB SETUP data stage for a selected standard, HID or custom request, with selected fields parametrised or driven at run time.
- Streams the stage byte-wise with valid/ready handshake, appending the USB CRC16, into the low-speed DATA0 packet serializer.
- Sits between the enumeration sequencer (start/req_sel) and the PID/NRZI serializer (tx_*).

Parameters:
CFG_LEN, 9, wLength for GET_DESCRIPTOR(configuration) and (interface)
HID_RPT_LEN, 129, wLength for GET_DESCRIPTOR(HID report, 0x22)
STR_LEN, 4, wLength for GET_DESCRIPTOR(string)
CFG_VALUE, 1, wValue for SET_CONFIGURATION
RPT_LEN, 1, wLength for SET_REPORT
APPEND_CRC, 1, 1 = append CRC16 lo/hi bytes; 0 = 8 data bytes only
BIT_REV, 0, 1 = each output byte bit-reversed (bit0 on tx_byte[7]) for MSB-first shifters

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request strobe
req_sel  in  4  0 SET_ADDR, 1 GET_DEV, 2 GET_CFG, 3 GET_IF, 4 GET_EP, 5 GET_STR, 6 SET_CFG, 7 SET_IDLE, 8 GET_HID_RPT, 9 SET_REPORT, 10 CUSTOM
dev_addr  in  7  wValue[6:0] for SET_ADDR
str_idx  in  8  wValue low byte for GET_STR
custom_pkt  in  64  byte0 at [63:56] … byte7 at [7:0], used when req_sel=10
abort  in  1  synchronous cancel
tx_byte  out  8  current byte
tx_valid  out  1  tx_byte valid
tx_ready  in  1  downstream accepts byte
tx_last  out  1  marks final byte of packet
pkt_snapshot  out  64  latched setup packet, same byte order as custom_pkt
busy  out  1  transfer in progress
done  out  1  one-cycle pulse after final accept
err  out  1  one-cycle pulse on invalid req_sel

Behaviour:
- Reset: all outputs 0; state IDLE; CRC register 0xFFFF.
- Packet bytes (bmRequestType, bRequest, wValue lo/hi, wIndex lo/hi, wLength lo/hi):
  - SET_ADDR: 00 05 {0,dev_addr} 00 00 00 00 00
  - GET_DEV: 80 06 00 01 00 00 12 00
  - GET_CFG: 80 06 00 02 00 00 CFG_LEN
  - GET_IF: 80 06 00 04 00 00 CFG_LEN
  - GET_EP: 80 06 00 05 00 00 07 00
  - GET_STR: 80 06 str_idx 03 00 00 STR_LEN
  - SET_CFG: 00 09 CFG_VALUE 00 00 00 00 00
  - SET_IDLE: 21 0A 00 00 00 00 00 00
  - GET_HID_RPT: 81 06 00 22 00 00 HID_RPT_LEN
  - SET_REPORT: 21 09 00 02 00 00 RPT_LEN
  - CUSTOM: custom_pkt
  - 16-bit lengths are emitted little-endian.
- States and transitions:
  - IDLE: start with req_sel ≤ 10 → LOAD. Packet latched into pkt_snapshot; busy=1 next cycle.
  - IDLE: start with req_sel > 10 → err pulse next cycle; stay IDLE.
  - LOAD (1 cycle): index=0, CRC=0xFFFF → DATA. tx_valid rises 2 cycles after start.
  - DATA: present byte[index]. On tx_valid&tx_ready: CRC updated (poly 0x8005, LSB-first per bit), index++. After byte7 → CRC_LO if APPEND_CRC, else FIN.
  - CRC_LO / CRC_HI: present ~CRC[7:0], then ~CRC[15:8], each bit-ordered LSB-first per USB. Accept → next state.
  - FIN: done=1, busy=0, tx_valid=0 for one cycle → IDLE.
- tx_last=1 with the final byte: byte7 if APPEND_CRC=0, else CRC hi.
- Handshake rules:
  - tx_byte and tx_last are held stable while tx_valid & !tx_ready.
  - tx_valid never drops without an accept, except on abort or reset.
  - Back-to-back accepts give one byte per cycle.
- start while busy: ignored, no err.
- abort (any non-IDLE state): IDLE next cycle; tx_valid=0; no done. pkt_snapshot retained.
- abort and start in the same IDLE cycle: abort wins.
- BIT_REV applies to the output path only. CRC is always computed on the natural bytes.
- Async reset mid-packet: immediate return to reset values; no done.
- pkt_snapshot changes only on an accepted start.

Test Plan:
- GET_DEV, tx_ready=1: start@T → tx_valid@T+2. Bytes 80 06 00 01 00 00 12 00 + 2 CRC bytes on consecutive cycles; tx_last on 10th; done one cycle after; pkt_snapshot=0x8006000100001200.
- SET_ADDR dev_addr=0x05, APPEND_CRC=1: bytes 00 05 05 00 00 00 00 00. Recomputing the USB CRC16 over all 10 bytes yields residual 0x800D.
- GET_HID_RPT with tx_ready toggled 1-0-0-1 randomly: tx_byte stable during stalls. Byte6=0x81, byte3=0x22; exactly 10 accepts; single done.
- req_sel=12: err pulse, busy/tx_valid stay 0. start during DATA index 3: ignored, stream continues unchanged.
- abort after 4th accept: tx_valid=0 and busy=0 next cycle, no done. A following start(SET_IDLE) emits 21 0A 00… from byte0.
- BIT_REV=1, APPEND_CRC=0, CUSTOM=0x0102030405060708: bytes 80 40 C0 20 A0 60 E0 10; tx_last on 8th. rst_n low mid-stream: all outputs 0 immediately.
